serial_rca: RTL and testbench

//  Bit-serial ripple-carry adder: the addition counterpart of the 4-bit ripple-carry

---
 rtl/arith_pkg.sv | 10 +
 rtl/full_adder.sv | 13 +
 rtl/serial_rca.sv | 99 +++++++++
 tb/tb_serial_rca.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the serial arithmetic blocks: FSM state encodings.
package arith_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage : arith_pkg

// File: rtl/full_adder.sv
// One-bit combinational full adder, reused once per clock by the serial adder.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule : full_adder

// File: rtl/serial_rca.sv
// Bit-serial ripple-carry adder: one full adder iterated LSB first over WIDTH clocks,
// with a start/busy/done handshake. Result is a + b + cin mod 2^WIDTH plus carry-out.
module serial_rca
   import arith_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry
);

   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sr, b_sr, r_sr;
   logic             c_q;
   logic [CNT_W-1:0] cnt_q;
   logic             fa_s, fa_co;
   logic             last_bit_c;

   full_adder u_fa (
      .a   (a_sr[0]),
      .b   (b_sr[0]),
      .cin (c_q),
      .s   (fa_s),
      .cout(fa_co)
   );

   assign last_bit_c = (cnt_q == CNT_W'(WIDTH - 1));

   // State register; busy/done are registered decodes of the next state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         busy    <= (state_d == ST_RUN);
         done    <= (state_d == ST_DONE);
      end
   end

   // Next-state logic; the unused encoding falls back to IDLE
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start)      state_d = ST_RUN;
         ST_RUN:  if (last_bit_c) state_d = ST_DONE;
         ST_DONE:                 state_d = ST_IDLE;
         default:                 state_d = ST_IDLE;
      endcase
   end

   // Datapath: load on accept, shift one bit per RUN cycle, publish on the last bit
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_sr  <= '0;
         b_sr  <= '0;
         r_sr  <= '0;
         c_q   <= 1'b0;
         cnt_q <= '0;
         sum   <= '0;
         carry <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  a_sr  <= a;
                  b_sr  <= b;
                  c_q   <= cin;
                  cnt_q <= '0;
               end
            end
            ST_RUN: begin
               a_sr  <= a_sr >> 1;
               b_sr  <= b_sr >> 1;
               r_sr  <= {fa_s, r_sr[WIDTH-1:1]};
               c_q   <= fa_co;
               cnt_q <= cnt_q + CNT_W'(1);
               if (last_bit_c) begin
                  sum   <= {fa_s, r_sr[WIDTH-1:1]};
                  carry <= fa_co;
               end
            end
            default: ;
         endcase
      end
   end

endmodule : serial_rca

// File: tb/tb_serial_rca.sv
// Self-checking bench for serial_rca: timeline model checked every cycle plus directed cases.
module tb_serial_rca;

   localparam int unsigned W = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         busy, done, carry;
   logic [W-1:0] sum;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int done_cnt = 0;
   bit chk_en = 1'b0;

   serial_rca #(.WIDTH(W)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .start(start),
      .a    (a),
      .b    (b),
      .cin  (cin),
      .busy (busy),
      .done (done),
      .sum  (sum),
      .carry(carry)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: ph counts cycles since acceptance (0 idle, 1..W busy, W+1 done)
   int       ph = 0;
   logic [W:0] p_res = '0;
   logic [W:0] m_res = '0;

   always @(posedge clk) begin
      if (!rst_n) begin
         ph    <= 0;
         m_res <= '0;
      end else if (ph == 0) begin
         if (start) begin
            p_res <= (W+1)'(a) + (W+1)'(b) + (W+1)'(cin);
            ph    <= 1;
         end
      end else if (ph == W) begin
         m_res <= p_res;
         ph    <= W + 1;
      end else if (ph == W + 1) begin
         ph <= 0;
      end else begin
         ph <= ph + 1;
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy",  32'(busy),  32'(ph >= 1 && ph <= W));
         chk("done",  32'(done),  32'(ph == W + 1));
         chk("sum",   32'(sum),   32'(m_res[W-1:0]));
         chk("carry", 32'(carry), 32'(m_res[W]));
         chk("busy_and_done", 32'(busy & done), 32'(0));
      end
      if (done === 1'b1) done_cnt++;
   end

   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                         output logic [W-1:0] rs, output logic rc, output int lat);
      @(negedge clk);
      a = ta; b = tb_; cin = tc; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      while (done !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      if (done !== 1'b1) begin
         n_chk++; n_fail++;
         $display("FAIL timeout: no done after %0d cycles, required %0d", lat, W);
      end
      rs = sum;
      rc = carry;
      @(negedge clk);
   endtask

   logic [W-1:0] rs;
   logic         rc;
   int           lat, dc0, mism;
   int           dcyc[6];

   initial begin
      // Reset 2 cycles
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_sum", 32'(sum), 32'(0));
      chk("rst_carry", 32'(carry), 32'(0));
      rst_n = 1'b1;

      // 1: basic add and latency
      run_op(4'h4, 4'h3, 1'b0, rs, rc, lat);
      chk("t1_sum", 32'(rs), 32'h7);
      chk("t1_carry", 32'(rc), 32'(0));
      chk("t1_latency", 32'(lat), 32'(W));

      // 2: wrap-around
      run_op(4'hF, 4'h1, 1'b0, rs, rc, lat);
      chk("t2a_sum", 32'(rs), 32'h0);
      chk("t2a_carry", 32'(rc), 32'(1));
      run_op(4'hF, 4'hF, 1'b1, rs, rc, lat);
      chk("t2b_sum", 32'(rs), 32'hF);
      chk("t2b_carry", 32'(rc), 32'(1));

      // 3: start while busy is dropped
      dc0 = done_cnt;
      @(negedge clk);
      a = 4'h1; b = 4'h1; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      a = 4'h8; b = 4'h8; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (W + 6) @(negedge clk);
      chk("t3_sum", 32'(sum), 32'h2);
      chk("t3_carry", 32'(carry), 32'(0));
      chk("t3_done_pulses", 32'(done_cnt - dc0), 32'(1));

      // 4: reset during the third RUN cycle
      @(negedge clk);
      a = 4'h9; b = 4'h9; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      chk("t4_busy_before", 32'(busy), 32'(1));
      rst_n = 1'b0;
      @(negedge clk);
      chk("t4_busy", 32'(busy), 32'(0));
      chk("t4_done", 32'(done), 32'(0));
      chk("t4_sum", 32'(sum), 32'(0));
      chk("t4_carry", 32'(carry), 32'(0));
      rst_n = 1'b1;
      dc0 = done_cnt;
      repeat (W + 4) @(negedge clk);
      chk("t4_no_done", 32'(done_cnt - dc0), 32'(0));

      // 5: exhaustive
      mism = 0;
      for (int ia = 0; ia < 16; ia++)
         for (int ib = 0; ib < 16; ib++)
            for (int ic = 0; ic < 2; ic++) begin
               run_op(4'(ia), 4'(ib), 1'(ic), rs, rc, lat);
               if ({rc, rs} !== 5'(ia + ib + ic)) mism++;
            end
      chk("t5_mismatches", 32'(mism), 32'(0));

      // 6: start held high -> one operation every W+2 cycles
      @(negedge clk);
      a = 4'h5; b = 4'h6; cin = 1'b1; start = 1'b1;
      for (int k = 0; k < 6; k++) begin
         lat = 0;
         while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
            a = W'($urandom_range(15)); b = W'($urandom_range(15)); cin = 1'($urandom_range(1));
         end
         if (done !== 1'b1) begin
            n_chk++; n_fail++;
            $display("FAIL t6_timeout: no done within %0d cycles", lat);
         end
         dcyc[k] = cyc;
         @(negedge clk);
      end
      start = 1'b0;
      for (int k = 1; k < 6; k++)
         chk("t6_period", 32'(dcyc[k] - dcyc[k-1]), 32'(W + 2));
      repeat (W + 4) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule : tb_serial_rca
